// File: rtl/omi_phy_lane_model.sv
// One direction of a DLx serial lane bundle: fixed pipeline delay, 66b bit-slip
// rotation per lane, lane blanking and single-bit error injection.
module omi_phy_lane_model #(
    parameter int NUM_LANES = 8,
    parameter int DATA_W    = 64,
    parameter int HDR_W     = 2,
    parameter int LATENCY   = 2,
    parameter int SLIP_HOLD = 32,
    parameter int INIT_SLIP = 0,
    localparam int SYM_W    = DATA_W + HDR_W,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int HOLD_W   = (SLIP_HOLD > 0) ? $clog2(SLIP_HOLD + 1) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES*DATA_W-1:0]   tx_data,
    input  logic [NUM_LANES*HDR_W-1:0]    tx_header,
    input  logic [NUM_LANES-1:0]          rx_slip,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic                          inj_en,
    input  logic [LANE_W-1:0]             inj_lane,
    input  logic [6:0]                    inj_bit,
    output logic [NUM_LANES-1:0]          rx_valid,
    output logic [NUM_LANES*DATA_W-1:0]   rx_data,
    output logic [NUM_LANES*HDR_W-1:0]    rx_header,
    output logic [NUM_LANES*7-1:0]        slip_ofs,
    output logic [15:0]                   inj_count
);

    logic              inj_ok;
    logic              inj_pend_q;
    logic [LANE_W-1:0] inj_lane_q;
    logic [6:0]        inj_bit_q;
    logic [15:0]       inj_count_q;

    assign inj_ok = inj_en && (inj_bit < 7'(SYM_W))
                    && ({1'b0, inj_lane} < (LANE_W + 1)'(NUM_LANES));

    // The request is held one cycle so the flip lands on the word registered after it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inj_pend_q  <= 1'b0;
            inj_lane_q  <= '0;
            inj_bit_q   <= '0;
            inj_count_q <= '0;
        end else begin
            inj_pend_q <= inj_ok;
            inj_lane_q <= inj_lane;
            inj_bit_q  <= inj_bit;
            if (inj_ok && (inj_count_q != 16'hFFFF)) begin
                inj_count_q <= inj_count_q + 16'd1;
            end
        end
    end

    assign inj_count = inj_count_q;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [SYM_W-1:0]   pipe_q [LATENCY];
        logic [SYM_W-1:0]   sym_in;
        logic [SYM_W-1:0]   cur;
        logic [SYM_W-1:0]   prev;
        logic [2*SYM_W-1:0] cat;
        logic [SYM_W-1:0]   rot;
        logic [SYM_W-1:0]   flip;
        logic [SYM_W-1:0]   out_q;
        logic               valid_q;
        logic [6:0]         ofs_q;
        logic [HOLD_W-1:0]  hold_q;
        logic               accept;

        assign sym_in = {tx_header[gi*HDR_W +: HDR_W], tx_data[gi*DATA_W +: DATA_W]};

        // cur is combinational so the output register adds the final cycle of delay.
        if (LATENCY == 1) begin : g_lat1
            assign cur = sym_in;
        end else begin : g_latn
            assign cur = pipe_q[LATENCY-2];
        end
        assign prev = pipe_q[LATENCY-1];

        assign cat    = {prev, cur};
        assign rot    = SYM_W'(cat >> ofs_q);
        assign flip   = (inj_pend_q && (inj_lane_q == LANE_W'(gi)))
                        ? (SYM_W'(1) << inj_bit_q) : '0;
        assign accept = rx_slip[gi] && (hold_q == '0);

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int j = 0; j < LATENCY; j++) begin
                    pipe_q[j] <= '0;
                end
                ofs_q   <= 7'(INIT_SLIP);
                hold_q  <= '0;
                valid_q <= 1'b0;
                out_q   <= '0;
            end else begin
                pipe_q[0] <= sym_in;
                for (int j = 1; j < LATENCY; j++) begin
                    pipe_q[j] <= pipe_q[j-1];
                end
                if (accept) begin
                    ofs_q  <= (ofs_q == 7'(SYM_W - 1)) ? 7'd0 : ofs_q + 7'd1;
                    hold_q <= HOLD_W'(SLIP_HOLD);
                end else if (hold_q != '0) begin
                    hold_q <= hold_q - HOLD_W'(1);
                end
                valid_q <= lane_en[gi] && !accept;
                out_q   <= lane_en[gi] ? (rot ^ flip) : '0;
            end
        end

        assign rx_valid[gi]                  = valid_q;
        assign rx_data[gi*DATA_W +: DATA_W]  = out_q[DATA_W-1:0];
        assign rx_header[gi*HDR_W +: HDR_W]  = out_q[SYM_W-1 -: HDR_W];
        assign slip_ofs[gi*7 +: 7]           = ofs_q;
    end

endmodule
